// File: rtl/fp_divider_seq.sv
// Sequential 12-bit float divider: restoring mantissa division, one quotient bit per clock,
// followed by a single normalise/exponent cycle. Start/done handshake, results held until next done.
module fp_divider_seq #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 7,
  parameter int BIAS  = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   X,
  input  logic [EXP_W+MAN_W:0]   Y,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   Z,
  output logic                   OF,
  output logic                   UF
);

  localparam int W        = 1 + EXP_W + MAN_W;
  localparam int MW       = MAN_W + 1;
  localparam int QW       = MAN_W + 2;
  localparam int EW       = EXP_W + 2;
  localparam int CW       = $clog2(MAN_W + 2);
  localparam int CNT_INIT = MAN_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_capture;

  logic                r_zs;
  logic [EXP_W-1:0]    r_xe;
  logic [EXP_W-1:0]    r_ye;
  logic [MW-1:0]       r_ym;
  logic [QW-1:0]       r_r;
  logic [QW-1:0]       r_q;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [W-1:0]        r_z;
  logic                r_of;
  logic                r_uf;

  logic                w_ge;
  logic [QW-1:0]       w_rem;
  logic                w_adj;
  logic [MAN_W-1:0]    w_zm;
  logic signed [EW-1:0] w_e;
  logic                w_of;
  logic                w_uf;

  // Quotient is in [2^(QW-2), 2^QW); drop the implicit one from whichever bit leads (truncating).
  function automatic logic [MAN_W-1:0] f_man(input logic [QW-1:0] q);
    return q[QW-1] ? q[QW-2:1] : q[QW-3:0];
  endfunction

  function automatic logic signed [EW-1:0] f_exp(input logic [EXP_W-1:0] xe,
                                                 input logic [EXP_W-1:0] ye,
                                                 input logic             adj);
    logic signed [EW-1:0] bias_s;
    logic signed [EW-1:0] adj_s;
    bias_s = EW'(BIAS);
    adj_s  = {{(EW-1){1'b0}}, adj};
    return $signed({2'b00, xe}) - $signed({2'b00, ye}) + bias_s - adj_s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_next    = S_DIV;
        w_capture = 1'b1;
      end
      S_DIV:  if (r_cnt == '0) w_next = S_NORM;
      S_NORM: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_ge  = (r_r >= {1'b0, r_ym});
  assign w_rem = w_ge ? (r_r - {1'b0, r_ym}) : r_r;
  assign w_adj = ~r_q[QW-1];
  assign w_zm  = f_man(r_q);
  assign w_e   = f_exp(r_xe, r_ye, w_adj);
  assign w_uf  = w_e[EW-1];
  // Non-negative exponent overflows when any bit above the field is set.
  assign w_of  = ~w_e[EW-1] & (|w_e[EW-2:EXP_W]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zs   <= 1'b0;
      r_xe   <= '0;
      r_ye   <= '0;
      r_ym   <= '0;
      r_r    <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_z    <= '0;
      r_of   <= 1'b0;
      r_uf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_capture) begin
        r_zs   <= X[W-1] ^ Y[W-1];
        r_xe   <= X[W-2:MAN_W];
        r_ye   <= Y[W-2:MAN_W];
        r_ym   <= {1'b1, Y[MAN_W-1:0]};
        r_r    <= {2'b01, X[MAN_W-1:0]};
        r_q    <= '0;
        r_cnt  <= CW'(CNT_INIT);
        r_busy <= 1'b1;
      end else if (r_state == S_DIV) begin
        r_q   <= {r_q[QW-2:0], w_ge};
        r_r   <= {w_rem[QW-2:0], 1'b0};
        r_cnt <= r_cnt - 1'b1;
      end else if (r_state == S_NORM) begin
        r_z    <= {r_zs, w_e[EXP_W-1:0], w_zm};
        r_of   <= w_of;
        r_uf   <= w_uf;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Z    = r_z;
  assign OF   = r_of;
  assign UF   = r_uf;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Bench for fp_divider_seq: table vectors, random vectors against an integer-division model,
// and hand-written handshake/reset sequences; results checked from a scoreboard queue on done.
module tb_fp_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] X;
  logic [11:0] Y;
  logic        busy;
  logic        done;
  logic [11:0] Z;
  logic        OF;
  logic        UF;

  typedef struct {
    logic [11:0] z;
    logic        of;
    logic        uf;
    int          cap;
  } exp_t;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] z;
    logic        of;
    logic        uf;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  fp_divider_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .X     (X),
    .Y     (Y),
    .busy  (busy),
    .done  (done),
    .Z     (Z),
    .OF    (OF),
    .UF    (UF)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk12(input string nm, input logic [11:0] act, input logic [11:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%03h, expected 0x%03h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, req);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [11:0] x, input logic [11:0] y);
    exp_t m;
    int xm, ym, q, zm, adj, e;
    xm = 128 + int'(x[6:0]);
    ym = 128 + int'(y[6:0]);
    q  = (xm * 256) / ym;
    if (q >= 256) begin
      zm  = (q >> 1) & 127;
      adj = 0;
    end else begin
      zm  = q & 127;
      adj = 1;
    end
    e     = int'(x[10:7]) - int'(y[10:7]) + 7 - adj;
    m.z   = {x[11] ^ y[11], 4'(e & 15), 7'(zm)};
    m.of  = (e > 15);
    m.uf  = (e < 0);
    m.cap = 0;
    return m;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || done) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout: busy=%b done=%b after %0d cycles", busy, done, k);
    end
  endtask

  task automatic run_op(input logic [11:0] x, input logic [11:0] y, input exp_t e);
    exp_t ee;
    ee = e;
    @(negedge clk);
    X = x; Y = y; start = 1'b1;
    ee.cap = cyc + 1;
    sb.push_back(ee);
    @(negedge clk);
    start = 1'b0;
    chk1("busy_after_capture", busy, 1'b1);
    wait_idle();
    chk12("Z_held", Z, ee.z);
  endtask

  initial begin
    exp_t e;
    tbl[0] = '{12'h440, 12'h400, 12'h3C0, 1'b0, 1'b0};
    tbl[1] = '{12'h380, 12'h3C0, 12'h32A, 1'b0, 1'b0};
    tbl[2] = '{12'hC40, 12'h400, 12'hBC0, 1'b0, 1'b0};
    tbl[3] = '{12'hC40, 12'hC00, 12'h3C0, 1'b0, 1'b0};
    tbl[4] = '{12'h780, 12'h000, 12'h300, 1'b1, 1'b0};
    tbl[5] = '{12'h000, 12'h780, 12'h400, 1'b0, 1'b1};
    tbl[6] = '{12'h3FF, 12'h3FF, 12'h380, 1'b0, 1'b0};
    tbl[7] = '{12'h780, 12'h380, 12'h780, 1'b0, 1'b0};
    tbl[8] = '{12'h000, 12'h380, 12'h000, 1'b0, 1'b0};
    tbl[9] = '{12'h000, 12'h3C0, 12'h7AA, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; X = '0; Y = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && done) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_done: done=1 with Z=0x%03h and no pending operation", Z);
          end else begin
            automatic exp_t ex = sb.pop_front();
            chk12("Z", Z, ex.z);
            chk1("OF", OF, ex.of);
            chk1("UF", UF, ex.uf);
            chk_int("latency", cyc - ex.cap, 10);
            chk1("busy_at_done", busy, 1'b0);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk12("rst_Z", Z, 12'h000);
    chk1("rst_OF", OF, 1'b0);
    chk1("rst_UF", UF, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      e.z = tbl[i].z; e.of = tbl[i].of; e.uf = tbl[i].uf; e.cap = 0;
      run_op(tbl[i].x, tbl[i].y, e);
    end

    for (int i = 0; i < 20; i++) begin
      logic [11:0] rx, ry;
      rx = 12'($urandom);
      ry = 12'($urandom);
      run_op(rx, ry, model(rx, ry));
    end

    // start pulsed again mid-division with new operands: must be ignored
    @(negedge clk);
    X = 12'h440; Y = 12'h400; start = 1'b1;
    e = model(12'h440, 12'h400);
    e.cap = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    X = 12'h380; Y = 12'h3C0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk12("ignored_start_Z", Z, 12'h3C0);

    // start held high: back-to-back operations 11 cycles apart, operands changed in flight
    @(negedge clk);
    X = 12'hC40; Y = 12'h400; start = 1'b1;
    e = model(12'hC40, 12'h400);
    e.cap = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    X = 12'h380; Y = 12'h3C0;
    e = model(12'h380, 12'h3C0);
    e.cap = cyc + 11;
    sb.push_back(e);
    repeat (11) @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk12("held_start_last_Z", Z, 12'h32A);

    // asynchronous reset in the middle of a division
    @(negedge clk);
    X = 12'h780; Y = 12'h000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk12("midrst_Z", Z, 12'h000);
    chk1("midrst_OF", OF, 1'b0);
    chk1("midrst_UF", UF, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk1("post_rst_busy", busy, 1'b0);
    chk12("post_rst_Z", Z, 12'h000);

    e = model(12'h440, 12'h400);
    run_op(12'h440, 12'h400, e);

    repeat (3) @(negedge clk);
    chk_int("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
